// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-bundle pipeline (ID/EX, EX/MEM, MEM/WB) for the 5-stage
// MIPS core, plus RAW stall, bubble, branch/jump flush and PC select logic.
// Build option: define CTRL_PIPE_FWD_EN to generate the ALU forwarding selects
// and restrict stalls to load-use. Without it, the forwarding selects are tied
// to the register file and every EX/MEM RAW dependency stalls.
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       id_alu_op,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_2_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_jump,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_2_reg,
  output logic [REG_W-1:0] wb_dst,
  output logic             stall,
  output logic             flush_ifid,
  output logic [1:0]       pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_WB    = 2'd1;
  localparam logic [1:0] FWD_MEM   = 2'd2;

  // A stage "writes r" only for a live, register-writing bundle; r0 is never a target.
  function automatic logic writes(input logic vld, input logic reg_write,
                                  input logic [REG_W-1:0] dst,
                                  input logic [REG_W-1:0] r);
    return vld & reg_write & (dst == r) & (r != '0);
  endfunction

  // ID/EX stage register (_p0)
  logic [1:0]       alu_op_p0;
  logic             alu_src_p0, reg_dst_p0, branch_p0, mem_read_p0;
  logic             mem_write_p0, reg_write_p0, mem_2_reg_p0, vld_p0;
  logic [REG_W-1:0] rs_p0, rt_p0, rd_p0;

  // EX/MEM stage register (_p1)
  logic             branch_p1, mem_read_p1, mem_write_p1, reg_write_p1;
  logic             mem_2_reg_p1, vld_p1;
  logic [REG_W-1:0] dst_p1;

  // MEM/WB stage register (_p2)
  logic             reg_write_p2, mem_2_reg_p2, vld_p2;
  logic [REG_W-1:0] dst_p2;

  logic [REG_W-1:0] ex_dst;
  logic             branch_taken;
  logic             hazard;

  assign ex_dst       = reg_dst_p0 ? rd_p0 : rt_p0;
  assign branch_taken = branch_p1 & mem_zero;

`ifdef CTRL_PIPE_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

  // With forwarding only a load still in EX cannot supply its result in time.
  assign hazard = mem_read_p0 &
                  (writes(vld_p0, reg_write_p0, ex_dst, id_rs) |
                   writes(vld_p0, reg_write_p0, ex_dst, id_rt));

  assign fwd_a = fwd_sel(writes(vld_p1, reg_write_p1, dst_p1, rs_p0),
                         writes(vld_p2, reg_write_p2, dst_p2, rs_p0));
  assign fwd_b = fwd_sel(writes(vld_p1, reg_write_p1, dst_p1, rt_p0),
                         writes(vld_p2, reg_write_p2, dst_p2, rt_p0));
`else
  // Without forwarding any pending EX or MEM write to a source stalls; WB is
  // covered by the write-before-read register file.
  assign hazard = writes(vld_p0, reg_write_p0, ex_dst, id_rs) |
                  writes(vld_p0, reg_write_p0, ex_dst, id_rt) |
                  writes(vld_p1, reg_write_p1, dst_p1, id_rs) |
                  writes(vld_p1, reg_write_p1, dst_p1, id_rt);

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  // ex_rs is only consumed by the forwarding selects.
  logic unused_ex_rs;
  assign unused_ex_rs = ^rs_p0;
`endif

  // Flow control: a taken branch overrides stalls, a stall overrides a jump.
  always_comb begin
    stall      = 1'b0;
    flush_ifid = 1'b0;
    pc_sel     = PC_SEQ;
    if (!rst) begin
      if (branch_taken) begin
        flush_ifid = 1'b1;
        pc_sel     = PC_BRANCH;
      end else if (hazard) begin
        stall = 1'b1;
      end else if (id_jump) begin
        flush_ifid = 1'b1;
        pc_sel     = PC_JUMP;
      end
    end
  end

  // ID/EX: load the decoded bundle, or a bubble on a stall or branch squash.
  always_ff @(posedge clk) begin
    if (rst || branch_taken || stall) begin
      alu_op_p0    <= '0;
      alu_src_p0   <= 1'b0;
      reg_dst_p0   <= 1'b0;
      branch_p0    <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
      reg_write_p0 <= 1'b0;
      mem_2_reg_p0 <= 1'b0;
      rs_p0        <= '0;
      rt_p0        <= '0;
      rd_p0        <= '0;
      vld_p0       <= 1'b0;
    end else begin
      alu_op_p0    <= id_alu_op;
      alu_src_p0   <= id_alu_src;
      reg_dst_p0   <= id_reg_dst;
      branch_p0    <= id_branch;
      mem_read_p0  <= id_mem_read;
      mem_write_p0 <= id_mem_write;
      reg_write_p0 <= id_reg_write;
      mem_2_reg_p0 <= id_mem_2_reg;
      rs_p0        <= id_rs;
      rt_p0        <= id_rt;
      rd_p0        <= id_rd;
      vld_p0       <= 1'b1;
    end
  end

  // EX/MEM: advance from EX, squashed along with ID/EX on a taken branch.
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      branch_p1    <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_2_reg_p1 <= 1'b0;
      dst_p1       <= '0;
      vld_p1       <= 1'b0;
    end else begin
      branch_p1    <= branch_p0;
      mem_read_p1  <= mem_read_p0;
      mem_write_p1 <= mem_write_p0;
      reg_write_p1 <= reg_write_p0;
      mem_2_reg_p1 <= mem_2_reg_p0;
      dst_p1       <= ex_dst;
      vld_p1       <= vld_p0;
    end
  end

  // MEM/WB: always advances; the branch in MEM itself is harmless in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_p2 <= 1'b0;
      mem_2_reg_p2 <= 1'b0;
      dst_p2       <= '0;
      vld_p2       <= 1'b0;
    end else begin
      reg_write_p2 <= reg_write_p1;
      mem_2_reg_p2 <= mem_2_reg_p1;
      dst_p2       <= dst_p1;
      vld_p2       <= vld_p1;
    end
  end

  assign ex_alu_op     = alu_op_p0;
  assign ex_alu_src    = alu_src_p0;
  assign ex_reg_dst    = reg_dst_p0;
  assign mem_mem_read  = mem_read_p1;
  assign mem_mem_write = mem_write_p1;
  assign wb_reg_write  = reg_write_p2 & vld_p2;
  assign wb_mem_2_reg  = mem_2_reg_p2;
  assign wb_dst        = dst_p2;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the opcode decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core, and presents each stage's control signals to the datapath. It also owns hazard handling for control flow:
- detects RAW hazards and generates stalls;
- inserts bubbles;
- flushes on taken branches and jumps;
- optionally generates forwarding selects.

## Interface
Parameters:
- REG_W, 5, register-index width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_alu_op  in  2  decoded ALU op (0 add, 1 sub, 2 R-type).
- id_reg_dst, id_branch, id_mem_read, id_mem_2_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  in  1 each  decoded control bits of the ID-stage instruction.
- id_rs, id_rt, id_rd  in  REG_W  register fields of the ID-stage instruction.
- mem_zero  in  1  ALU zero flag registered into the MEM stage.
- ex_alu_op  out  2  ALU op for EX.
- ex_alu_src, ex_reg_dst  out  1  EX muxes.
- mem_mem_read, mem_mem_write  out  1  data-memory strobes.
- wb_reg_write, wb_mem_2_reg  out  1  writeback controls.
- wb_dst  out  REG_W  writeback register index.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  replace IF/ID with a NOP next edge.
- pc_sel  out  2  0 PC+4, 1 branch target (MEM), 2 jump target (ID).
- fwd_a, fwd_b  out  2  ALU operand selects: 0 regfile, 1 WB value, 2 MEM value.

## Operation
- Stage registers:
  - ID/EX holds alu_op, alu_src, reg_dst, branch, mem_read, mem_write, reg_write, mem_2_reg, rs, rt, rd.
  - EX/MEM holds branch, mem_read, mem_write, reg_write, mem_2_reg, dst.
  - MEM/WB holds reg_write, mem_2_reg, dst.
- EX destination: ex_dst = ex_reg_dst ? ex_rd : ex_rt, combinational. It is registered into EX/MEM as mem_dst.
- A stage "writes r" when its reg_write=1, its dst=r and r≠0. Register 0 never causes a hazard or a forward.
- branch_taken = mem_branch & mem_zero.
- Load-use hazard: ex_mem_read=1 and the EX stage writes id_rs or id_rt.
- Per-edge priority, highest first:
  1. rst: all stage registers go to 0.
  2. branch_taken: ID/EX and EX/MEM load zeros (bubbles). flush_ifid=1, pc_sel=1. MEM/WB advances normally. stall is forced to 0.
  3. stall: ID/EX loads zeros. EX/MEM and MEM/WB advance. IF/ID is held by the fetch stage.
  4. Normal: every register advances.
- Jump: id_jump=1 with no stall and no branch_taken gives pc_sel=2 and flush_ifid=1. The jump itself enters ID/EX as a bubble, because its reg_write and mem bits are 0.
- The decoder default (unknown opcode, all zeros) propagates as a NOP.

## Timing
- Outputs are registered except stall, flush_ifid, pc_sel, fwd_a, fwd_b, which are combinational from stage registers and ID inputs.
- Reset values: every registered output is 0. Consequently stall=0, flush_ifid=0, pc_sel=0 and fwd_a=fwd_b=0 one cycle after reset.
- Latency: an ID-stage bundle appears on ex_* 1 cycle later, on mem_* 2 cycles later, and on wb_* 3 cycles later.
- The load-use stall is exactly 1 cycle. The next cycle the load is in MEM, so the hazard condition is false (FWD_EN) or the MEM-stage RAW check applies (no FWD_EN).
- Branch penalty: 3 instructions squashed (IF/ID, ID/EX, EX/MEM).
- Reset asserted mid-operation clears everything on that edge. In-flight stores are dropped: mem_mem_write=0 from that edge.

## Configuration
- CTRL_PIPE_FWD_EN defined:
  - fwd_a is computed for ex_rs and fwd_b for ex_rt.
  - Select is 2 if the MEM stage writes the register, else 1 if the WB stage writes it, else 0. MEM has priority.
  - stall = load-use hazard only.
- CTRL_PIPE_FWD_EN undefined:
  - fwd_a=fwd_b=0 constant.
  - stall=1 whenever id_rs or id_rt is written by the EX stage or the MEM stage.
  - WB is not checked; the register file is write-before-read.
  - Each stall inserts 1 bubble. It re-evaluates every cycle until clear, max 2 cycles per dependency.

## Test plan
- Reset: hold rst with random inputs for 3 cycles -> all outputs 0. Release with an R-type bundle (alu_op=2, reg_write=1, rd=5) -> ex_alu_op=2 after 1 edge, wb_reg_write=1 and wb_dst=5 after 3 edges.
- Load-use: lw with rt=8, followed by add with rs=8 -> stall=1 for exactly 1 cycle and ex_* all zero on the next cycle. With FWD_EN, fwd_a=1 when the add reaches EX.
- Forward priority (FWD_EN): add r3 in MEM and add r3 in WB while the EX instruction reads rs=3 -> fwd_a=2. Same case with dst=0 -> fwd_a=0.
- Taken branch: beq with mem_zero=1 in MEM, stall condition also true that cycle -> stall=0, pc_sel=1, flush_ifid=1, ex_/mem_ write strobes 0 on the next edge.
- Jump: id_jump=1 -> pc_sel=2 and flush_ifid=1 in the same cycle. The next cycle carries no reg_write/mem_write anywhere from the jump.
- No-forward build: add r4 followed by sub reading r4 -> stall=1 for 2 consecutive cycles, then the sub advances.
